// File: rtl/sensor_drain_pkg.sv
// -----------------------------------------------------------------------------
// sensor_drain_pkg
//   Shared types and constants for the sensor_drain block.
//   - state_t        : drain FSM states
//   - *_DEF          : default buffer geometry and bus width
//   - WORD_SHIFT     : word index -> byte offset shift (32-bit words)
//   - align_word()   : force a byte address onto a word boundary
//   - word_addr()    : base + word index, as a byte address (wraps mod 2^32)
// -----------------------------------------------------------------------------
package sensor_drain_pkg;

  localparam int DEPTH_DEF  = 64;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int WORD_SHIFT = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RD    = 3'd2,
    S_WR    = 3'd3,
    S_CLEAR = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Low two address bits are dropped; masking (rather than slicing) keeps
  // every input bit read.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

  // Natural 32-bit overflow gives the required modulo-2^32 wrap.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] widx);
    return base + (widx << WORD_SHIFT);
  endfunction

endpackage

// File: rtl/sensor_drain.sv
// -----------------------------------------------------------------------------
// sensor_drain
//   Arms sensor_ctrl, waits for its buffer-full interrupt, then copies all
//   DEPTH buffered words to memory (base address latched from dst_base on ARM
//   entry) over a valid/ready write channel. Afterwards it clears sensor_ctrl
//   and pulses done. With enable held high it loops frame after frame.
//
// Ports
//   clk, rst          : clock; asynchronous active-low reset
//   enable            : level, 1 = keep collecting/draining frames
//   dst_base          : destination byte address (word aligned by the block)
//   sctrl_interrupt   : sensor_ctrl buffer full (only honoured in ARM)
//   sctrl_out         : sensor_ctrl read data for sctrl_addr (combinational)
//   sctrl_en          : collect enable to sensor_ctrl (ARM only)
//   sctrl_clear       : one-cycle clear to sensor_ctrl
//   sctrl_addr        : buffer read index
//   wr_valid/ready    : write request handshake
//   wr_addr, wr_data  : write byte address and data, stable while wr_valid
//   busy              : any state other than IDLE
//   done              : one-cycle pulse per completed frame
//   frame_cnt         : completed frames since reset (wraps)
// -----------------------------------------------------------------------------
module sensor_drain
  import sensor_drain_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [31:0]       dst_base,
  input  logic              sctrl_interrupt,
  input  logic [DATA_W-1:0] sctrl_out,
  output logic              sctrl_en,
  output logic              sctrl_clear,
  output logic [ADDR_W-1:0] sctrl_addr,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [31:0]       wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       base_q;
  // Set when CLEAR is reached from an abandoned ARM; steers CLEAR back to IDLE
  // so a partial frame never produces done or bumps frame_cnt.
  logic              aborted;

  // Control outputs are pure state decodes; reset forces IDLE, so they drop
  // the instant rst goes low, no clock needed.
  assign sctrl_en    = (state == S_ARM);
  assign sctrl_clear = (state == S_CLEAR);
  assign wr_valid    = (state == S_WR);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign sctrl_addr  = idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      base_q    <= '0;
      aborted   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            base_q <= align_word(dst_base);
            state  <= S_ARM;
          end
        end

        // A full buffer wins over a simultaneous enable drop: the data is
        // already captured, so drain it.
        S_ARM: begin
          if (sctrl_interrupt) begin
            idx     <= '0;
            aborted <= 1'b0;
            state   <= S_RD;
          end else if (!enable) begin
            aborted <= 1'b1;
            state   <= S_CLEAR;
          end
        end

        // One cycle to fetch the word; the write beat is then launched from
        // registers so wr_addr/wr_data are stable for the whole WR phase.
        S_RD: begin
          wr_data <= sctrl_out;
          wr_addr <= word_addr(base_q, 32'(idx));
          state   <= S_WR;
        end

        S_WR: begin
          if (wr_ready) begin
            if (idx == LAST_IDX) begin
              state <= S_CLEAR;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_RD;
            end
          end
        end

        S_CLEAR: begin
          idx   <= '0;
          state <= aborted ? S_IDLE : S_DONE;
        end

        // enable is only consulted here and in IDLE/ARM: a drop during the
        // drain lets the frame finish and then parks in IDLE.
        S_DONE: begin
          frame_cnt <= frame_cnt + 16'd1;
          if (enable) begin
            base_q <= align_word(dst_base);
            state  <= S_ARM;
          end else begin
            state  <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_drain.sv
module tb_sensor_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] dst_base;
  logic        sctrl_interrupt;
  logic [31:0] sctrl_out;
  logic        sctrl_en;
  logic        sctrl_clear;
  logic [5:0]  sctrl_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;

  logic [31:0] buffer [64];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int clr_cnt = 0;
  int done_cnt = 0;
  int checks = 0;
  int failures = 0;

  assign sctrl_out = buffer[sctrl_addr];

  sensor_drain dut (
    .clk(clk), .rst(rst), .enable(enable), .dst_base(dst_base),
    .sctrl_interrupt(sctrl_interrupt), .sctrl_out(sctrl_out),
    .sctrl_en(sctrl_en), .sctrl_clear(sctrl_clear), .sctrl_addr(sctrl_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Inputs only change #1 after a rising edge, so the negedge view equals
  // what the next rising edge will sample.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_valid && wr_ready) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (sctrl_clear) clr_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic fill_buf(input logic [31:0] pat);
    for (int i = 0; i < 64; i++) buffer[i] = pat + 32'(i);
  endtask

  task automatic arm();
    enable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic fire_irq();
    @(posedge clk); #1 sctrl_interrupt = 1'b1;
    @(posedge clk); #1 sctrl_interrupt = 1'b0;
  endtask

  // cyc counts cycles after fire_irq returns; the cycle showing done is cyc.
  task automatic wait_done(input bit drop_en, output int cyc, output bit ok,
                           output bit en_seen);
    cyc = 0; ok = 1'b0; en_seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      cyc++;
      if (sctrl_en) en_seen = 1'b1;
      if (done) begin
        ok = 1'b1;
        if (drop_en) begin #1 enable = 1'b0; end
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    checks++; if (sctrl_en !== 1'b0 || sctrl_clear !== 1'b0) begin failures++; $display("FAIL reset_sctrl got en=%b clr=%b exp=0/0", sctrl_en, sctrl_clear); end
    checks++; if (sctrl_addr !== 6'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", sctrl_addr); end
    checks++; if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr got addr=%h data=%h exp=0/0", wr_addr, wr_data); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit ok; bit en_seen; int c0;
    fill_buf(32'hA000_0000); wa_q.delete(); wd_q.delete();
    dst_base = 32'h0001_0000; wr_ready = 1'b1;
    arm();
    @(negedge clk);
    checks++; if (sctrl_en !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_arm got en=%b busy=%b exp=1/1", sctrl_en, busy); end
    c0 = clr_cnt;
    fire_irq();
    wait_done(1'b1, cyc, ok, en_seen);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=none exp=done"); end
    checks++; if (cyc !== 130) begin failures++; $display("FAIL basic_latency got=%0d exp=130", cyc); end
    checks++; if (wa_q.size() !== 64) begin failures++; $display("FAIL basic_count got=%0d exp=64", wa_q.size()); end
    for (int i = 0; i < 64 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'h0001_0000 + 32'(4*i) || wd_q[i] !== 32'hA000_0000 + 32'(i)) begin
        failures++; $display("FAIL basic_word%0d got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], 32'h0001_0000 + 32'(4*i), 32'hA000_0000 + 32'(i));
      end
    end
    checks++; if (clr_cnt - c0 !== 1) begin failures++; $display("FAIL basic_clears got=%0d exp=1", clr_cnt - c0); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL basic_frame_cnt got=%0d exp=1", frame_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    int cyc; bit ok; bit en_seen; bit found;
    fill_buf(32'hB000_0000); wa_q.delete(); wd_q.delete();
    dst_base = 32'h0001_0000; wr_ready = 1'b1;
    arm();
    fire_irq();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (busy && !wr_valid && !sctrl_en && !sctrl_clear && !done && sctrl_addr == 6'd10) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL bp_find_rd10 got=timeout exp=RD10"); end
    @(posedge clk); #1 wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_held c%0d got=%b exp=1", k, wr_valid); end
      checks++; if (wr_addr !== 32'h0001_0028) begin failures++; $display("FAIL bp_addr_held c%0d got=%h exp=00010028", k, wr_addr); end
      checks++; if (wr_data !== 32'hB000_000A) begin failures++; $display("FAIL bp_data_held c%0d got=%h exp=b000000a", k, wr_data); end
    end
    @(posedge clk); #1 wr_ready = 1'b1;
    wait_done(1'b1, cyc, ok, en_seen);
    checks++; if (!ok) begin failures++; $display("FAIL bp_done_timeout got=none exp=done"); end
    checks++; if (wa_q.size() !== 64) begin failures++; $display("FAIL bp_count got=%0d exp=64", wa_q.size()); end
    for (int i = 0; i < 64 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'h0001_0000 + 32'(4*i) || wd_q[i] !== 32'hB000_0000 + 32'(i)) begin
        failures++; $display("FAIL bp_word%0d got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], 32'h0001_0000 + 32'(4*i), 32'hB000_0000 + 32'(i));
      end
    end
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL bp_frame_cnt got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_abort();
    int c0; int d0;
    wa_q.delete(); wd_q.delete();
    c0 = clr_cnt; d0 = done_cnt;
    arm();
    @(posedge clk); #1 enable = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (clr_cnt - c0 !== 1) begin failures++; $display("FAIL abort_clears got=%0d exp=1", clr_cnt - c0); end
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL abort_done got=%0d exp=%0d", done_cnt, d0); end
    checks++; if (wa_q.size() !== 0) begin failures++; $display("FAIL abort_writes got=%0d exp=0", wa_q.size()); end
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL abort_frame_cnt got=%0d exp=2", frame_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_disable_mid();
    int cyc; bit ok; bit en_seen; bit found;
    fill_buf(32'hD000_0000); wa_q.delete(); wd_q.delete();
    dst_base = 32'h0001_0000;
    arm();
    fire_irq();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (wr_valid && sctrl_addr == 6'd20) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL dis_find_wr20 got=timeout exp=WR20"); end
    @(posedge clk); #1 enable = 1'b0;
    wait_done(1'b0, cyc, ok, en_seen);
    checks++; if (!ok) begin failures++; $display("FAIL dis_done_timeout got=none exp=done"); end
    checks++; if (en_seen !== 1'b0) begin failures++; $display("FAIL dis_sctrl_en got=%b exp=0", en_seen); end
    checks++; if (wa_q.size() !== 64) begin failures++; $display("FAIL dis_count got=%0d exp=64", wa_q.size()); end
    for (int i = 0; i < 64 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'h0001_0000 + 32'(4*i) || wd_q[i] !== 32'hD000_0000 + 32'(i)) begin
        failures++; $display("FAIL dis_word%0d got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], 32'h0001_0000 + 32'(4*i), 32'hD000_0000 + 32'(i));
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || sctrl_en !== 1'b0) begin failures++; $display("FAIL dis_idle got busy=%b en=%b exp=0/0", busy, sctrl_en); end
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL dis_frame_cnt got=%0d exp=3", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit ok; bit en_seen; bit found;
    fill_buf(32'hE000_0000); wa_q.delete(); wd_q.delete();
    dst_base = 32'h0001_0000;
    arm();
    fire_irq();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (wr_valid && sctrl_addr == 6'd5) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL b2b_find_wr5 got=timeout exp=WR5"); end
    @(posedge clk); #1 dst_base = 32'h0002_0000;
    wait_done(1'b0, cyc, ok, en_seen);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done1_timeout got=none exp=done"); end
    checks++; if (sctrl_en !== 1'b1) begin failures++; $display("FAIL b2b_rearm got=%b exp=1", sctrl_en); end
    checks++; if (wa_q.size() !== 64) begin failures++; $display("FAIL b2b_count1 got=%0d exp=64", wa_q.size()); end
    for (int i = 0; i < 64 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'h0001_0000 + 32'(4*i) || wd_q[i] !== 32'hE000_0000 + 32'(i)) begin
        failures++; $display("FAIL b2b_f1_word%0d got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], 32'h0001_0000 + 32'(4*i), 32'hE000_0000 + 32'(i));
      end
    end
    checks++; if (frame_cnt !== 16'd4) begin failures++; $display("FAIL b2b_frame_cnt1 got=%0d exp=4", frame_cnt); end
    fill_buf(32'hF000_0000); wa_q.delete(); wd_q.delete();
    fire_irq();
    wait_done(1'b1, cyc, ok, en_seen);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done2_timeout got=none exp=done"); end
    checks++; if (wa_q.size() !== 64) begin failures++; $display("FAIL b2b_count2 got=%0d exp=64", wa_q.size()); end
    for (int i = 0; i < 64 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'h0002_0000 + 32'(4*i) || wd_q[i] !== 32'hF000_0000 + 32'(i)) begin
        failures++; $display("FAIL b2b_f2_word%0d got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], 32'h0002_0000 + 32'(4*i), 32'hF000_0000 + 32'(i));
      end
    end
    checks++; if (frame_cnt !== 16'd5) begin failures++; $display("FAIL b2b_frame_cnt2 got=%0d exp=5", frame_cnt); end
  endtask

  // Unaligned base near the top of memory: low bits dropped, addresses wrap.
  task automatic test_wrap();
    int cyc; bit ok; bit en_seen; logic [31:0] ea;
    fill_buf(32'h1234_0000); wa_q.delete(); wd_q.delete();
    dst_base = 32'hFFFF_FF83;
    arm();
    fire_irq();
    wait_done(1'b1, cyc, ok, en_seen);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_done_timeout got=none exp=done"); end
    checks++; if (wa_q.size() !== 64) begin failures++; $display("FAIL wrap_count got=%0d exp=64", wa_q.size()); end
    for (int i = 0; i < 64 && i < wa_q.size(); i++) begin
      ea = (i < 32) ? 32'hFFFF_FF80 + 32'(4*i) : 32'(4*(i-32));
      checks++;
      if (wa_q[i] !== ea || wd_q[i] !== 32'h1234_0000 + 32'(i)) begin
        failures++; $display("FAIL wrap_word%0d got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], ea, 32'h1234_0000 + 32'(i));
      end
    end
    checks++; if (frame_cnt !== 16'd6) begin failures++; $display("FAIL wrap_frame_cnt got=%0d exp=6", frame_cnt); end
  endtask

  task automatic test_async_reset();
    bit found; int c0;
    fill_buf(32'h5555_0000);
    dst_base = 32'h0001_0000;
    arm();
    fire_irq();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (wr_valid) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL ar_find_wr got=timeout exp=WR"); end
    c0 = clr_cnt;
    #2 rst = 1'b0;
    #1;
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL ar_wr_valid got=%b exp=0", wr_valid); end
    checks++; if (sctrl_en !== 1'b0 || sctrl_clear !== 1'b0) begin failures++; $display("FAIL ar_sctrl got en=%b clr=%b exp=0/0", sctrl_en, sctrl_clear); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", busy); end
    enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || wr_valid !== 1'b0) begin failures++; $display("FAIL ar_idle got busy=%b valid=%b exp=0/0", busy, wr_valid); end
    checks++; if (sctrl_addr !== 6'd0) begin failures++; $display("FAIL ar_idx got=%0d exp=0", sctrl_addr); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL ar_frame_cnt got=%0d exp=0", frame_cnt); end
    checks++; if (clr_cnt !== c0) begin failures++; $display("FAIL ar_no_clear got=%0d exp=%0d", clr_cnt, c0); end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; dst_base = '0; sctrl_interrupt = 1'b0; wr_ready = 1'b0;
    fill_buf(32'h0);
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_disable_mid();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
